// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer owning HI/LO: iterative multiply and restoring divide.
// Define MDU_FAST_MUL_EN for a single-cycle multiplier; divide is identical in both builds.
module mdu_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [5:0]  op,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  input  logic        rd_req,
  input  logic        rd_sel,
  input  logic        cancel,
  output logic        ready,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_W = 5;

  localparam logic [5:0] OP_MULT  = 6'b000001;
  localparam logic [5:0] OP_MULTU = 6'b000010;
  localparam logic [5:0] OP_DIV   = 6'b000100;
  localparam logic [5:0] OP_DIVU  = 6'b001000;
  localparam logic [5:0] OP_MTHI  = 6'b010000;
  localparam logic [5:0] OP_MTLO  = 6'b100000;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        div_q;
  logic [31:0]        div_r;
  logic [31:0]        div_d;
  logic               neg_q;
  logic               neg_r;
  logic               accept;
  logic [32:0]        r_sh;
  logic [32:0]        diff;
  logic [31:0]        r_nxt;
  logic [31:0]        q_nxt;
`ifndef MDU_FAST_MUL_EN
  logic [31:0]        mul_a;
  logic [31:0]        mul_b;
  logic               mul_sgn;
`endif

  // Operands are extended to 64 bits; the low 64 bits of that product are the exact result.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{sgn & a[31]}}, a};
    eb = {{32{sgn & b[31]}}, b};
    return ea * eb;
  endfunction

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (32'(0) - x) : x;
  endfunction

  assign ready   = !(busy && (op_valid || rd_req));
  assign accept  = op_valid && ready && !cancel;
  assign rd_data = rd_req ? (rd_sel ? hi : lo) : 32'(0);

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_sh  = {div_r, div_q[31]};
    diff  = r_sh - {1'b0, div_d};
    r_nxt = diff[32] ? r_sh[31:0] : diff[31:0];
    q_nxt = {div_q[30:0], ~diff[32]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      div_q <= '0;
      div_r <= '0;
      div_d <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`ifndef MDU_FAST_MUL_EN
      mul_a   <= '0;
      mul_b   <= '0;
      mul_sgn <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi <= in0;
              OP_MTLO: lo <= in0;
              OP_MULT, OP_MULTU: begin
`ifdef MDU_FAST_MUL_EN
                {hi, lo} <= mul64(in0, in1, op[0]);
`else
                mul_a   <= in0;
                mul_b   <= in1;
                mul_sgn <= op[0];
                cnt     <= CNT_W'(MUL_LAT - 1);
                state   <= MUL;
                busy    <= 1'b1;
`endif
              end
              OP_DIV, OP_DIVU: begin
                // Divide by zero retires immediately and leaves HI/LO alone.
                if (in1 != 32'(0)) begin
                  div_q <= mag32(in0, op[2]);
                  div_d <= mag32(in1, op[2]);
                  div_r <= '0;
                  neg_q <= op[2] & (in0[31] ^ in1[31]);
                  neg_r <= op[2] & in0[31];
                  cnt   <= CNT_W'(31);
                  state <= DIV;
                  busy  <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
`ifndef MDU_FAST_MUL_EN
        MUL: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == '0) begin
            {hi, lo} <= mul64(mul_a, mul_b, mul_sgn);
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        DIV: begin
          if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            div_q <= q_nxt;
            div_r <= r_nxt;
            if (cnt == '0) begin
              lo    <= neg_q ? (32'(0) - q_nxt) : q_nxt;
              hi    <= neg_r ? (32'(0) - r_nxt) : r_nxt;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: HI/LO moves, multiply/divide results and timing, cancel and reset.
module tb_mdu_ctrl;

  localparam int unsigned MUL_LAT = 4;

  localparam logic [5:0] OP_MULT  = 6'b000001;
  localparam logic [5:0] OP_MULTU = 6'b000010;
  localparam logic [5:0] OP_DIV   = 6'b000100;
  localparam logic [5:0] OP_DIVU  = 6'b001000;
  localparam logic [5:0] OP_MTHI  = 6'b010000;
  localparam logic [5:0] OP_MTLO  = 6'b100000;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [5:0]  op;
  logic [31:0] in0;
  logic [31:0] in1;
  logic        rd_req;
  logic        rd_sel;
  logic        cancel;
  logic        ready;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op       (op),
    .in0      (in0),
    .in1      (in1),
    .rd_req   (rd_req),
    .rd_sel   (rd_sel),
    .cancel   (cancel),
    .ready    (ready),
    .busy     (busy),
    .rd_data  (rd_data),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single cycle; returns in the cycle after the accept edge.
  task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op       = o;
    in0      = a;
    in1      = b;
    #1;
    chk("issue_ready", 32'(ready), 32'd1);
    tick();
    op_valid = 1'b0;
    op       = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_mul(input string tag, input logic [5:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    issue(o, a, b);
`ifndef MDU_FAST_MUL_EN
    for (int i = 1; i <= int'(MUL_LAT); i++) begin
      #1;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
    end
`endif
    #1;
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  // Divide with MFLO/MFHI held through the whole operation.
  task automatic check_div(input string tag, input logic [5:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_hi,
                           input logic [31:0] exp_lo);
    issue(o, a, b);
    rd_req = 1'b1;
    rd_sel = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      #1;
      chk({tag, "_stall"}, 32'(ready), 32'd0);
      tick();
    end
    #1;
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mflo"}, rd_data, exp_lo);
    rd_sel = 1'b1;
    #1;
    chk({tag, "_mfhi"}, rd_data, exp_hi);
    rd_req = 1'b0;
    rd_sel = 1'b0;
  endtask

  initial begin
    op_valid = 1'b0;
    op       = '0;
    in0      = '0;
    in1      = '0;
    rd_req   = 1'b0;
    rd_sel   = 1'b0;
    cancel   = 1'b0;
    do_reset();

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_rd", rd_data, 32'h0);

    // MTHI then MFHI the next cycle
    issue(OP_MTHI, 32'hCAFEF00D, 32'h0);
    rd_req = 1'b1;
    rd_sel = 1'b1;
    #1;
    chk("mfhi_data", rd_data, 32'hCAFEF00D);
    chk("mfhi_ready", 32'(ready), 32'd1);
    chk("mthi_busy", 32'(busy), 32'd0);
    rd_req = 1'b0;
    tick();

    check_mul("mult", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    tick();
    check_mul("multu", OP_MULTU, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1);
    tick();

    check_div("div", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    tick();
    check_div("divu", OP_DIVU, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC);
    tick();
    check_div("divovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
    tick();

    // Divide by zero leaves HI/LO untouched
    issue(OP_MTHI, 32'h11, 32'h0);
    issue(OP_MTLO, 32'h22, 32'h0);
    issue(OP_DIVU, 32'd7, 32'd0);
    #1;
    chk("div0_busy", 32'(busy), 32'd0);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);
    tick();

    // Cancel in T+10
    issue(OP_DIVU, 32'd1000, 32'd3);
    for (int i = 1; i < 10; i++) tick();
    cancel = 1'b1;
    #1;
    chk("cancel_busy_before", 32'(busy), 32'd1);
    tick();
    cancel = 1'b0;
    #1;
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_hi", hi, 32'h11);
    chk("cancel_lo", lo, 32'h22);
    tick();
    tick();
    #1;
    chk("cancel_hi_later", hi, 32'h11);
    chk("cancel_lo_later", lo, 32'h22);

    // Reset in T+10
    issue(OP_DIVU, 32'd1000, 32'd3);
    for (int i = 1; i < 10; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ready", 32'(ready), 32'd1);
    chk("rstmid_hi", hi, 32'h0);
    chk("rstmid_lo", lo, 32'h0);
    chk("rstmid_rd", rd_data, 32'h0);
    tick();

    // Back-to-back: MTLO held from T+30 is accepted in the cycle busy falls
    issue(OP_DIVU, 32'd100, 32'd7);
    for (int i = 1; i < 30; i++) tick();
    op_valid = 1'b1;
    op       = OP_MTLO;
    in0      = 32'h55;
    for (int i = 30; i <= 32; i++) begin
      #1;
      chk("b2b_stall", 32'(ready), 32'd0);
      tick();
    end
    #1;
    chk("b2b_ready", 32'(ready), 32'd1);
    chk("b2b_hi", hi, 32'd2);
    chk("b2b_lo", lo, 32'd14);
    tick();
    op_valid = 1'b0;
    op       = '0;
    #1;
    chk("b2b_mtlo", lo, 32'h55);
    chk("b2b_busy", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
